// File: rtl/ppwm_prog_tx.sv
// Serial programming transmitter for the PPWM instruction memory.
// Frames are a high start bit then the word MSB first, sent on a divided data/clock pair.
module ppwm_prog_tx #(
    parameter int INSTR_WIDTH = 7,
    parameter int DEPTH       = 16,
    parameter int CLK_DIV     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   word_valid_i,
    input  logic [INSTR_WIDTH-1:0] word_i,
    output logic                   word_ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   data_o,
    output logic                   clk_data_o
);
    localparam int FRAME_BITS = INSTR_WIDTH + 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int WORD_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(DEPTH - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_W-1:0]       word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic                    phase_q, phase_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            phase_q    <= 1'b0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
        end
    end

    // phase_q is the serial clock level; it toggles every CLK_DIV cycles and
    // the shift register only advances when a high half-period finishes.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        phase_d    = phase_q;
        shift_d    = shift_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (word_valid_i) begin
                    shift_d   = {1'b1, word_i};
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    phase_d   = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            if (word_cnt_q == WORD_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                                state_d    = S_LOAD;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            shift_d   = shift_q << 1;
                        end
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
        end
    end

    assign word_ready_o = (state_q == S_LOAD);
    assign busy_o       = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done_o       = (state_q == S_DONE);
    assign data_o       = (state_q == S_SHIFT) && shift_q[FRAME_BITS-1];
    assign clk_data_o   = (state_q == S_SHIFT) && phase_q;

endmodule

// File: tb/tb_ppwm_prog_tx.sv
// Directed bench for ppwm_prog_tx: table of words/expected frames, a serial receiver
// monitor, and hand-written abort, reset, stall and CLK_DIV=1 sequences.
module tb_ppwm_prog_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, abort_i, word_valid_i;
    logic [6:0] word_i;
    logic       word_ready_o, busy_o, done_o, data_o, clk_data_o;

    logic       start1, abort1, valid1;
    logic [6:0] word1;
    logic       ready1, busy1, done1, data1, cdo1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ppwm_prog_tx dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .word_valid_i(word_valid_i), .word_i(word_i),
        .word_ready_o(word_ready_o), .busy_o(busy_o), .done_o(done_o),
        .data_o(data_o), .clk_data_o(clk_data_o)
    );

    ppwm_prog_tx #(.INSTR_WIDTH(7), .DEPTH(1), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .abort_i(abort1),
        .word_valid_i(valid1), .word_i(word1),
        .word_ready_o(ready1), .busy_o(busy1), .done_o(done1),
        .data_o(data1), .clk_data_o(cdo1)
    );

    typedef struct {
        logic [6:0] word;
        logic [7:0] exp_frame;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial receiver model for the default-parameter instance.
    logic [7:0] rx_q[$];
    int         len_q[$];
    logic [7:0] rx_acc;
    int         rx_nbits = 0;
    int         len_cnt = 0;
    logic       prev_data = 1'b0;
    logic       prev_clk = 1'b0;
    logic       mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!(busy_o && !word_ready_o)) begin
                chk("idle_lines", {30'd0, data_o, clk_data_o}, 32'd0);
                rx_nbits = 0;
                if (len_cnt != 0) len_q.push_back(len_cnt);
                len_cnt = 0;
            end else begin
                len_cnt++;
                if (clk_data_o) begin
                    chk("data_stable", {31'd0, data_o}, {31'd0, prev_data});
                    if (!prev_clk) begin
                        rx_acc = {rx_acc[6:0], data_o};
                        rx_nbits++;
                        if (rx_nbits == 8) begin
                            rx_q.push_back(rx_acc);
                            rx_nbits = 0;
                        end
                    end
                end
            end
            prev_data = data_o;
            prev_clk  = clk_data_o;
        end
    end

    task automatic clear_sb();
        rx_q.delete();
        len_q.delete();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Entered and left on a negedge; leaves at SHIFT cycle 1 of the last word.
    task automatic feed(input int n, input int hold_at, input int start_at);
        for (int k = 0; k < n; k++) begin
            int t;
            if (k == start_at) begin
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
            word_i       = tbl[k].word;
            word_valid_i = (k != hold_at);
            t = 0;
            while (!word_ready_o && t < 300) begin
                @(negedge clk);
                t++;
            end
            chk("ready_timeout", {31'd0, word_ready_o}, 32'd1);
            if (k == hold_at) begin
                for (int h = 0; h < 10; h++) begin
                    @(negedge clk);
                    chk("stall_state", {29'd0, word_ready_o, data_o, clk_data_o}, 32'b100);
                end
                word_valid_i = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (k == hold_at)
                chk("stall_resume", {28'd0, busy_o, word_ready_o, data_o, clk_data_o}, 32'b1010);
        end
        word_valid_i = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int t = 1;
        while (!done_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_latency"}, t, 65);
        @(negedge clk);
        chk({tag, "_after_done"}, {30'd0, done_o, busy_o}, 32'd0);
        chk({tag, "_frame_count"}, rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk($sformatf("%s_frame%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, tbl[i].exp_frame});
        chk({tag, "_len_count"}, len_q.size(), 16);
        for (int i = 0; i < len_q.size(); i++)
            chk($sformatf("%s_len%0d", tag, i), len_q[i], 64);
        clear_sb();
    endtask

    initial begin
        logic [15:0] pat;
        logic [7:0]  bits1;
        logic        pc;
        int          t;

        tbl[0]  = '{7'h7F, 8'hFF}; tbl[1]  = '{7'h00, 8'h80};
        tbl[2]  = '{7'h55, 8'hD5}; tbl[3]  = '{7'h2A, 8'hAA};
        tbl[4]  = '{7'h01, 8'h81}; tbl[5]  = '{7'h40, 8'hC0};
        tbl[6]  = '{7'h3C, 8'hBC}; tbl[7]  = '{7'h12, 8'h92};
        tbl[8]  = '{7'h63, 8'hE3}; tbl[9]  = '{7'h0F, 8'h8F};
        tbl[10] = '{7'h70, 8'hF0}; tbl[11] = '{7'h5A, 8'hDA};
        tbl[12] = '{7'h25, 8'hA5}; tbl[13] = '{7'h11, 8'h91};
        tbl[14] = '{7'h6E, 8'hEE}; tbl[15] = '{7'h33, 8'hB3};

        rst = 1'b1; start_i = 0; abort_i = 0; word_valid_i = 0; word_i = 0;
        start1 = 0; abort1 = 0; valid1 = 0; word1 = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {27'd0, word_ready_o, busy_o, done_o, data_o, clk_data_o}, 32'd0);
        chk("reset_outputs1", {27'd0, ready1, busy1, done1, data1, cdo1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // abort beats start in IDLE
        start_i = 1; abort_i = 1;
        @(negedge clk);
        start_i = 0; abort_i = 0;
        chk("abort_over_start", {31'd0, busy_o}, 32'd0);

        // Run with valid held high and a stray start mid-run
        pulse_start();
        feed(16, -1, 8);
        finish_run("run1");

        // Run with a 10-cycle stall before word 4
        pulse_start();
        feed(16, 4, -1);
        finish_run("stall");

        // Abort mid-bit 5 of word 2
        pulse_start();
        feed(3, -1, -1);
        repeat (43) @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy_o}, 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_outputs", {27'd0, word_ready_o, busy_o, done_o, data_o, clk_data_o}, 32'd0);
        t = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_o || busy_o) t++;
        end
        chk("abort_no_done", t, 0);
        chk("abort_frames", rx_q.size(), 2);
        clear_sb();
        pulse_start();
        feed(16, -1, -1);
        finish_run("restart");

        // Reset while the serial clock is high
        pulse_start();
        feed(2, -1, -1);
        t = 0;
        while (!clk_data_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("clk_high_seen", {31'd0, clk_data_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {27'd0, word_ready_o, busy_o, done_o, data_o, clk_data_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_idle", {27'd0, word_ready_o, busy_o, done_o, data_o, clk_data_o}, 32'd0);
        clear_sb();

        // CLK_DIV=1 instance, single word 0x55
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; word1 = 7'h55; valid1 = 1'b1;
        chk("div1_ready", {31'd0, ready1}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0;
        pat = '0; bits1 = '0; pc = 1'b0;
        for (int c = 0; c < 16; c++) begin
            pat[c] = cdo1;
            if (cdo1 && !pc) bits1 = {bits1[6:0], data1};
            pc = cdo1;
            @(negedge clk);
        end
        chk("div1_clk_pattern", {16'd0, pat}, 32'h0000AAAA);
        chk("div1_bits", {24'd0, bits1}, 32'h000000D5);
        chk("div1_done", {30'd0, done1, busy1}, 32'b10);
        @(negedge clk);
        chk("div1_done_once", {31'd0, done1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ppwm_prog_tx.md
PPWM_PROG_TX -- requirements
Module: ppwm_prog_tx

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 7, bits per instruction word.
REQ-002 SHALL have parameter DEPTH, default 16, words sent per programming run.
REQ-003 SHALL have parameter CLK_DIV, default 4, clk cycles per serial-clock half period (legal range >=1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  begin a programming run (sampled in IDLE only).
REQ-007 SHALL have port abort_i  input  1  terminate any run immediately.
REQ-008 SHALL have port word_valid_i  input  1  word_i holds the next instruction.
REQ-009 SHALL have port word_i  input  INSTR_WIDTH  next instruction word.
REQ-010 SHALL have port word_ready_o  output  1  block accepts word_i this cycle.
REQ-011 SHALL have port busy_o  output  1  a run is in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse, run completed.
REQ-013 SHALL have port data_o  output  1  serial programming data to the PPWM memory.
REQ-014 SHALL have port clk_data_o  output  1  serial programming clock to the PPWM memory.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE: start_i=1 -> LOAD next cycle; word counter cleared to 0; otherwise stay.
REQ-017 LOAD: word_ready_o=1; word_valid_i=1 -> latch word_i into shift register, bit counter=0, divider=0, go SHIFT; word_valid_i=0 -> wait indefinitely, lines held low.
REQ-018 word_ready_o SHALL be 1 only in LOAD; a transfer occurs only on word_valid_i & word_ready_o.
REQ-019 Each word frame SHALL be INSTR_WIDTH+1 bits: high start bit first, then word bits MSB first.
REQ-020 Each bit SHALL occupy 2*CLK_DIV clk cycles: clk_data_o low for the first CLK_DIV, high for the second CLK_DIV.
REQ-021 data_o SHALL change only at the first cycle of a bit period (while clk_data_o low) and be stable across the clk_data_o rising edge.
REQ-022 One frame SHALL last exactly (INSTR_WIDTH+1)*2*CLK_DIV cycles in SHIFT.
REQ-023 End of frame: word counter == DEPTH-1 -> DONE; else word counter +1 and -> LOAD.
REQ-024 Outside SHIFT, data_o and clk_data_o SHALL both be 0.
REQ-025 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-026 busy_o SHALL be 1 in LOAD and SHIFT, 0 in IDLE and DONE.
REQ-027 start_i SHALL be ignored in LOAD, SHIFT, DONE.
REQ-028 abort_i=1 in any state SHALL force IDLE next cycle, data_o=clk_data_o=0, no done_o pulse; abort_i takes priority over start_i and word transfer in the same cycle.
REQ-029 Counter widths SHALL be $clog2 sized so DEPTH, INSTR_WIDTH+1 and CLK_DIV wrap exactly at their terminal counts (no overflow aliasing for any legal parameter).
REQ-030 CLK_DIV=1 SHALL yield a serial clock of clk/2 with identical frame format.

Reset
REQ-031 rst=1 SHALL, at the next clk edge, force IDLE and outputs word_ready_o=0, busy_o=0, done_o=0, data_o=0, clk_data_o=0, all counters 0, regardless of state.
REQ-032 Reset mid-frame SHALL truncate the frame with no further clk_data_o edges.

Verification
REQ-033 Defaults, start_i pulse, words 0x7F,0x00,... supplied with valid always 1 -> 16 frames, first frame bits 1,1,1,1,1,1,1,1, each frame 64 cycles, done_o single pulse after last, busy_o low after.
REQ-034 Word 0x55, CLK_DIV=1 -> data_o sequence 1,1,0,1,0,1,0,1 sampled on clk_data_o rising edges; frame 16 cycles.
REQ-035 word_valid_i held low 10 cycles in LOAD after word 3 -> lines stay 0, word_ready_o stays 1, frame 4 starts on cycle valid asserts.
REQ-036 abort_i asserted mid-bit 5 of word 2 -> next cycle IDLE, lines 0, busy_o 0, no done_o; new start_i restarts from word 0.
REQ-037 rst asserted during SHIFT with clk_data_o=1 -> next cycle all outputs 0; start_i during run ignored (word count unchanged, still 16 frames).
REQ-038 Scoreboard: serial receiver model (high start bit, clocked by clk_data_o) recovers all DEPTH words equal to supplied words in order.
